// File: rtl/alu_mul_seq.sv
// Shift-and-add sequencer for unsigned WIDTH x WIDTH -> 2*WIDTH multiplication
// using the shared combinational ALU for one add per multiplier bit.
`timescale 1ns/1ps
module alu_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [2:0]           alu_op,
  input  logic [WIDTH-1:0]     alu_z
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mc_q, mc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH-1:0]     op_a, op_b;
  logic                 carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mc_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mc_q      <= mc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mc_d      = mc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    op_a      = '0;
    op_b      = '0;
    carry     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mc_d    = mcand;
          lo_d    = mplier;
          hi_d    = '0;
          cnt_d   = '0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        op_a  = hi_q;
        op_b  = lo_q[0] ? mc_q : '0;
        // ALU only returns WIDTH bits, so recover the carry-out from the sign bits
        carry = (op_a[WIDTH-1] & op_b[WIDTH-1]) |
                ((op_a[WIDTH-1] | op_b[WIDTH-1]) & ~alu_z[WIDTH-1]);
        hi_d  = {carry, alu_z[WIDTH-1:1]};
        lo_d  = {alu_z[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          product_d = {carry, alu_z, lo_q[WIDTH-1:1]};
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign alu_a   = op_a;
  assign alu_b   = op_b;
  assign alu_op  = 3'b010;
  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed self-checking bench for alu_mul_seq with a behavioural adder as the ALU.
`timescale 1ns/1ps
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] mcand, mplier;
  logic        busy, done;
  logic [63:0] product;
  logic [31:0] alu_a, alu_b, alu_z;
  logic [2:0]  alu_op;

  int checks = 0;
  int failures = 0;
  int op_errs = 0;

  alu_mul_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .product(product),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z)
  );

  always #5 clk = ~clk;

  assign alu_z = (alu_op == 3'b010) ? (alu_a + alu_b) : 32'h0;

  always @(negedge clk) if (alu_op !== 3'b010) op_errs++;

  task automatic start_mul(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; mcand = a; mplier = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs from CALC cycle 0 until done, bounded; optionally pulses start with other operands
  task automatic wait_done(input logic [31:0] a, input logic [31:0] b, input int pulse_at,
                           output int cycles, output int busy_cycles, output int alub_errs);
    cycles = 0; busy_cycles = 0; alub_errs = 0;
    while (done !== 1'b1 && cycles < 100) begin
      if (busy === 1'b1) busy_cycles++;
      if (cycles < 32 && alu_b !== (b[cycles] ? a : 32'h0)) alub_errs++;
      if (cycles == pulse_at) begin
        start = 1'b1; mcand = ~a; mplier = ~b;
      end else if (cycles == pulse_at + 1) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic check_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp);
    int cyc, bc, ae;
    start_mul(a, b);
    wait_done(a, b, -1, cyc, bc, ae);
    checks++; if (cyc !== 32) begin failures++; $display("[TB] FAIL %s_latency: got %0d expected 32", name, cyc); end
    checks++; if (bc !== 32) begin failures++; $display("[TB] FAIL %s_busy_cycles: got %0d expected 32", name, bc); end
    checks++; if (ae !== 0) begin failures++; $display("[TB] FAIL %s_alu_b: got %0d bad cycles expected 0", name, ae); end
    checks++; if (product !== exp) begin failures++; $display("[TB] FAIL %s_product: got %h expected %h", name, product, exp); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL %s_busy_in_done: got %b expected 0", name, busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL %s_done_pulse: got %b expected 0", name, done); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mcand = '0; mplier = '0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (product !== 64'h0) begin failures++; $display("[TB] FAIL reset_product: got %h expected 0", product); end
    checks++; if (alu_a !== 32'h0 || alu_b !== 32'h0) begin failures++; $display("[TB] FAIL reset_alu_ab: got %h/%h expected 0/0", alu_a, alu_b); end
    checks++; if (alu_op !== 3'b010) begin failures++; $display("[TB] FAIL reset_alu_op: got %b expected 010", alu_op); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    check_mul("basic_3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
    check_mul("pattern", 32'hDEAD_BEEF, 32'h0000_0005, 64'h0000_0004_5964_BAAB);
  endtask

  task automatic test_carry();
    check_mul("carry", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
  endtask

  task automatic test_zero();
    check_mul("zero", 32'h0, 32'h1234_5678, 64'h0);
  endtask

  task automatic test_ignore_start();
    int cyc, bc, ae, extra;
    start_mul(32'd3, 32'd5);
    wait_done(32'd3, 32'd5, 9, cyc, bc, ae);
    checks++; if (cyc !== 32) begin failures++; $display("[TB] FAIL ignore_latency: got %0d expected 32", cyc); end
    checks++; if (product !== 64'd15) begin failures++; $display("[TB] FAIL ignore_product: got %h expected %h", product, 64'd15); end
    checks++; if (ae !== 0) begin failures++; $display("[TB] FAIL ignore_alu_b: got %0d bad cycles expected 0", ae); end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("[TB] FAIL ignore_single_done: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_back_to_back();
    int cyc, bc, ae;
    start_mul(32'd2, 32'd3);
    wait_done(32'd2, 32'd3, -1, cyc, bc, ae);
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL b2b_first_done: got %b expected 1", done); end
    checks++; if (product !== 64'd6) begin failures++; $display("[TB] FAIL b2b_first_product: got %h expected %h", product, 64'd6); end
    start = 1'b1; mcand = 32'd7; mplier = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_no_gap: got busy=%b expected 1", busy); end
    checks++; if (product !== 64'd6) begin failures++; $display("[TB] FAIL b2b_product_held: got %h expected %h", product, 64'd6); end
    wait_done(32'd7, 32'd9, -1, cyc, bc, ae);
    checks++; if (cyc !== 32) begin failures++; $display("[TB] FAIL b2b_latency: got %0d expected 32", cyc); end
    checks++; if (product !== 64'd63) begin failures++; $display("[TB] FAIL b2b_second_product: got %h expected %h", product, 64'd63); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int extra;
    start_mul(32'h1111_1111, 32'h0000_0002);
    repeat (14) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL midrst_busy_before: got %b expected 1", busy); end
    checks++; if (product !== 64'd63) begin failures++; $display("[TB] FAIL midrst_product_before: got %h expected %h", product, 64'd63); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
    checks++; if (product !== 64'h0) begin failures++; $display("[TB] FAIL midrst_product: got %h expected 0", product); end
    checks++; if (alu_a !== 32'h0 || alu_b !== 32'h0) begin failures++; $display("[TB] FAIL midrst_alu_ab: got %h/%h expected 0/0", alu_a, alu_b); end
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("[TB] FAIL midrst_no_done: got %0d active cycles expected 0", extra); end
    checks++; if (op_errs !== 0) begin failures++; $display("[TB] FAIL alu_op_const: got %0d bad cycles expected 0", op_errs); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
